mem_rw_fsm: RTL and testbench

//  Memory read/write machine-cycle generator (MR/MW, 3 T-states + waits).

---
 rtl/z80_bus_pkg.sv | 19 +
 rtl/mem_rw_fsm_if.sv | 31 +++
 rtl/mem_rw_fsm_latch.sv | 50 +++++
 rtl/mem_rw_fsm.sv | 173 +++++++++++++++++
 tb/tb_mem_rw_fsm.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/z80_bus_pkg.sv
// rtl/z80_bus_pkg.sv - shared Z80 bus types and constants for memory machine cycles
// Contents: mem_state_t (IDLE, T1, T2, TW, T3), strobe level constants and the
// default wait-state limit used by mem_rw_fsm.
package z80_bus_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    TW   = 3'd3,
    T3   = 3'd4
  } mem_state_t;

  localparam logic STROBE_OFF = 1'b1;
  localparam logic STROBE_ON  = 1'b0;

  localparam int MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/mem_rw_fsm_if.sv
// rtl/mem_rw_fsm_if.sv - memory-side bus of the MR/MW machine-cycle generator
// Parameters: ADDR_W address width, DATA_W data width.
// Modports:
//   master - cycle generator: drives MR_MREQ_L, MR_RD_L, MR_WR_L, MR_addr_out,
//            data_out, data_oe; samples data_in and WAIT_L
//   slave  - memory / arbiter side: the mirror image
interface mem_rw_fsm_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);

  logic              MR_MREQ_L;
  logic              MR_RD_L;
  logic              MR_WR_L;
  logic [ADDR_W-1:0] MR_addr_out;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic [DATA_W-1:0] data_in;
  logic              WAIT_L;

  modport master (
    output MR_MREQ_L, MR_RD_L, MR_WR_L, MR_addr_out, data_out, data_oe,
    input  data_in, WAIT_L
  );

  modport slave (
    input  MR_MREQ_L, MR_RD_L, MR_WR_L, MR_addr_out, data_out, data_oe,
    output data_in, WAIT_L
  );

endinterface

// File: rtl/mem_rw_fsm_latch.sv
// rtl/mem_rw_fsm_latch.sv - request latch (addr/wdata/write) and read-data latch
// Ports:
//   clk, rst_L            clock, asynchronous active-low reset
//   load_req              capture write_in/addr_in/wdata_in (cycle accepted)
//   write_in, addr_in,    request fields
//   wdata_in
//   load_rdata            capture data_in into rdata_q
//   data_in               memory data bus
//   write_q, addr_q,      latched request fields
//   wdata_q
//   rdata_q               latched read data, holds until the next load_rdata
module mem_rw_fsm_latch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              load_req,
  input  logic              write_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              load_rdata,
  input  logic [DATA_W-1:0] data_in,
  output logic              write_q,
  output logic [ADDR_W-1:0] addr_q,
  output logic [DATA_W-1:0] wdata_q,
  output logic [DATA_W-1:0] rdata_q
);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (load_req) begin
      write_q <= write_in;
      addr_q  <= addr_in;
      wdata_q <= wdata_in;
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      rdata_q <= '0;
    end else if (load_rdata) begin
      rdata_q <= data_in;
    end
  end

endmodule

// File: rtl/mem_rw_fsm.sv
// rtl/mem_rw_fsm.sv - memory read/write machine-cycle generator (T1, T2, TW*, T3)
// Parameters: ADDR_W, DATA_W, MAX_WAIT (consecutive wait states before abort).
// Build option: MEM_WAIT_SUPPORT_EN - when defined WAIT_L inserts TW states and
// a wait timeout aborts the cycle; when undefined WAIT_L is ignored, T2 always
// goes to T3 and abort stays 0.
// Ports:
//   clk, rst_L     clock, asynchronous active-low reset
//   start          request a cycle (taken in IDLE or T3)
//   write          1 = memory write, 0 = memory read
//   addr_in, wdata target address and write data, captured with start
//   busy           any state but IDLE
//   done           pulse in T3
//   rdata          last successfully read byte
//   rdata_valid    pulse in T3 of a successful read
//   abort          pulse in T3 of a cycle that hit the wait limit
//   bus            memory-side strobes, address/data drive, data_in, WAIT_L
module mem_rw_fsm
  import z80_bus_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              start,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              abort,
  mem_rw_fsm_if.master      bus
);

  mem_state_t        state_q, state_d;
  logic              accept;
  logic              in_wait_window;
  logic              wait_hold;
  logic              wait_timeout;
  logic              abort_q;
  logic              load_rdata;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              mreq_l, rd_l, wr_l, oe;
  logic [ADDR_W-1:0] addr_drv;

  assign in_wait_window = (state_q == T2) || (state_q == TW);
  assign accept         = start && ((state_q == IDLE) || (state_q == T3));
  // Read data is only taken on the edge that actually leaves for T3 cleanly.
  assign load_rdata     = in_wait_window && !write_q && !wait_hold;

`ifdef MEM_WAIT_SUPPORT_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign wait_hold    = in_wait_window && !bus.WAIT_L;
  // Limit reached while memory still not ready: give up and go to T3.
  assign wait_timeout = wait_hold && (wait_cnt == CNT_W'(MAX_WAIT));

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      wait_cnt <= '0;
      abort_q  <= 1'b0;
    end else begin
      if (state_q == T1) begin
        wait_cnt <= '0;
      end else if (wait_hold && !wait_timeout) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      // Registered so it lines up with the T3 cycle that follows the timeout.
      abort_q <= wait_timeout;
    end
  end
`else
  localparam int unused_max_wait = MAX_WAIT;
  logic unused_wait_l;

  assign unused_wait_l = bus.WAIT_L;
  assign wait_hold     = 1'b0;
  assign wait_timeout  = 1'b0;
  assign abort_q       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = T1;
      T1:      state_d = T2;
      T2, TW:  state_d = (wait_hold && !wait_timeout) ? TW : T3;
      T3:      state_d = start ? T1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = 1'b0;
    rdata_valid = 1'b0;
    abort       = 1'b0;
    mreq_l      = STROBE_OFF;
    rd_l        = STROBE_OFF;
    wr_l        = STROBE_OFF;
    oe          = 1'b0;
    addr_drv    = '0;
    case (state_q)
      T1: begin
        addr_drv = addr_q;
        mreq_l   = STROBE_ON;
        rd_l     = write_q ? STROBE_OFF : STROBE_ON;
      end
      T2, TW: begin
        addr_drv = addr_q;
        mreq_l   = STROBE_ON;
        rd_l     = write_q ? STROBE_OFF : STROBE_ON;
        wr_l     = write_q ? STROBE_ON : STROBE_OFF;
        oe       = write_q;
      end
      T3: begin
        addr_drv    = addr_q;
        done        = 1'b1;
        abort       = abort_q;
        rdata_valid = !write_q && !abort_q;
        // Writes keep the strobes for data hold time; reads release them.
        if (write_q) begin
          mreq_l = STROBE_ON;
          wr_l   = STROBE_ON;
          oe     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.MR_MREQ_L   = mreq_l;
  assign bus.MR_RD_L     = rd_l;
  assign bus.MR_WR_L     = wr_l;
  assign bus.MR_addr_out = addr_drv;
  assign bus.data_oe     = oe;
  assign bus.data_out    = wdata_q;

  mem_rw_fsm_latch #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_latch (
    .clk       (clk),
    .rst_L     (rst_L),
    .load_req  (accept),
    .write_in  (write),
    .addr_in   (addr_in),
    .wdata_in  (wdata),
    .load_rdata(load_rdata),
    .data_in   (bus.data_in),
    .write_q   (write_q),
    .addr_q    (addr_q),
    .wdata_q   (wdata_q),
    .rdata_q   (rdata)
  );

endmodule

// File: tb/tb_mem_rw_fsm.sv
// tb/tb_mem_rw_fsm.sv - self-checking bench for mem_rw_fsm
module tb_mem_rw_fsm;

  localparam int MAX_WAIT = 3;
`ifdef MEM_WAIT_SUPPORT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_L = 1'b0;
  logic        start = 1'b0;
  logic        write = 1'b0;
  logic [15:0] addr_in = '0;
  logic [7:0]  wdata = '0;
  logic        busy, done, rdata_valid, abort;
  logic [7:0]  rdata;

  mem_rw_fsm_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mem_rw_fsm #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .rst_L      (rst_L),
    .start      (start),
    .write      (write),
    .addr_in    (addr_in),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .abort      (abort),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: one request at a time, tracked by its position in the
  // cycle (1 = first cycle after acceptance), waits taken, and whether the
  // current cycle is the last one.
  logic        m_busy, m_final, m_abort, m_write;
  int          m_pos, m_waits;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;

  always @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      m_busy <= 1'b0; m_final <= 1'b0; m_abort <= 1'b0; m_write <= 1'b0;
      m_pos <= 0; m_waits <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0;
    end else if (!m_busy || m_final) begin
      m_final <= 1'b0; m_abort <= 1'b0; m_waits <= 0;
      if (start) begin
        m_busy <= 1'b1; m_pos <= 1;
        m_write <= write; m_addr <= addr_in; m_wdata <= wdata;
      end else begin
        m_busy <= 1'b0; m_pos <= 0;
      end
    end else if (m_pos == 1) begin
      m_pos <= 2;
    end else if (WAIT_EN && !bus.WAIT_L && m_waits == MAX_WAIT) begin
      m_final <= 1'b1; m_abort <= 1'b1;
    end else if (WAIT_EN && !bus.WAIT_L) begin
      m_waits <= m_waits + 1; m_pos <= m_pos + 1;
    end else begin
      m_final <= 1'b1;
      if (!m_write) m_rdata <= bus.data_in;
    end
  end

  logic        e_mreq_l, e_rd_l, e_wr_l, e_oe;
  logic [15:0] e_addr;
  assign e_mreq_l = !(m_busy && !(m_final && !m_write));
  assign e_rd_l   = !(m_busy && !m_write && !m_final);
  assign e_wr_l   = !(m_busy && m_write && m_pos >= 2);
  assign e_oe     = !e_wr_l;
  assign e_addr   = m_busy ? m_addr : 16'h0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_final));
      chk("abort", 32'(abort), 32'(m_final && m_abort));
      chk("rdata_valid", 32'(rdata_valid), 32'(m_final && !m_write && !m_abort));
      chk("MR_MREQ_L", 32'(bus.MR_MREQ_L), 32'(e_mreq_l));
      chk("MR_RD_L", 32'(bus.MR_RD_L), 32'(e_rd_l));
      chk("MR_WR_L", 32'(bus.MR_WR_L), 32'(e_wr_l));
      chk("data_oe", 32'(bus.data_oe), 32'(e_oe));
      chk("MR_addr_out", 32'(bus.MR_addr_out), 32'(e_addr));
      chk("rdata", 32'(rdata), 32'(m_rdata));
      if (e_oe) chk("data_out", 32'(bus.data_out), 32'(m_wdata));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issues one request and returns in its T3 cycle (no extra tick), so a
  // following call lands the next start in T3.
  task automatic run_cycle(input logic wr, input logic [15:0] a, input logic [7:0] wd,
                           input int nwait, input logic [7:0] din_wait, input logic [7:0] din_ok,
                           output int lat, output logic ab, output int dcyc);
    start = 1'b1; write = wr; addr_in = a; wdata = wd;
    tick();
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      bus.WAIT_L  = !(lat >= 2 && lat < 2 + nwait);
      bus.data_in = bus.WAIT_L ? din_ok : din_wait;
      tick();
      lat++;
    end
    chk("done_seen", 32'(done), 32'(1'b1));
    ab = abort;
    dcyc = cyc;
    bus.WAIT_L = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    int lat, c1, c2;
    logic ab;
    bus.WAIT_L = 1'b1;
    bus.data_in = 8'h00;
    tick();
    cmp_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_mreq", 32'(bus.MR_MREQ_L), 32'(1));
    chk("rst_rd", 32'(bus.MR_RD_L), 32'(1));
    chk("rst_wr", 32'(bus.MR_WR_L), 32'(1));
    chk("rst_addr", 32'(bus.MR_addr_out), 32'(0));
    chk("rst_data_out", 32'(bus.data_out), 32'(0));
    chk("rst_oe", 32'(bus.data_oe), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    tick();
    rst_L = 1'b1;
    tick();

    // 1: plain read
    run_cycle(1'b0, 16'h1234, 8'h00, 0, 8'hA5, 8'hA5, lat, ab, c1);
    chk("t1_latency", 32'(lat), 32'(3));
    chk("t1_rdata", 32'(rdata), 32'(8'hA5));
    chk("t1_rvalid", 32'(rdata_valid), 32'(1));
    tick();
    chk("t1_idle", 32'(busy), 32'(0));

    // 2: plain write
    run_cycle(1'b1, 16'h8000, 8'h3C, 0, 8'h00, 8'h00, lat, ab, c1);
    chk("t2_latency", 32'(lat), 32'(3));
    chk("t2_data_out", 32'(bus.data_out), 32'(8'h3C));
    chk("t2_oe", 32'(bus.data_oe), 32'(1));
    chk("t2_wr_t3", 32'(bus.MR_WR_L), 32'(0));
    chk("t2_rvalid", 32'(rdata_valid), 32'(0));
    chk("t2_rdata_kept", 32'(rdata), 32'(8'hA5));
    tick();

    // 3: read with two wait states; bus carries junk while not ready
    run_cycle(1'b0, 16'h2222, 8'h00, 2, 8'hFF, 8'h5A, lat, ab, c1);
    chk("t3_latency", 32'(lat), 32'(WAIT_EN ? 5 : 3));
    chk("t3_rdata", 32'(rdata), 32'(WAIT_EN ? 8'h5A : 8'hFF));
    tick();

    // 4: wait timeout
    run_cycle(1'b0, 16'h3333, 8'h00, 100, 8'h77, 8'h77, lat, ab, c1);
    chk("t4_latency", 32'(lat), 32'(WAIT_EN ? 6 : 3));
    chk("t4_abort", 32'(ab), 32'(WAIT_EN));
    chk("t4_rvalid", 32'(rdata_valid), 32'(!WAIT_EN));
    chk("t4_rdata", 32'(rdata), 32'(WAIT_EN ? 8'h5A : 8'h77));
    tick();

    // 5: back-to-back read then write
    run_cycle(1'b0, 16'h1000, 8'h00, 0, 8'hC3, 8'hC3, lat, ab, c1);
    run_cycle(1'b1, 16'h1001, 8'h99, 0, 8'h00, 8'h00, lat, ab, c2);
    chk("t5_gap", 32'(c2 - c1), 32'(3));
    chk("t5_addr", 32'(bus.MR_addr_out), 32'(16'h1001));
    chk("t5_rdata", 32'(rdata), 32'(8'hC3));
    tick();

    // 6a: start during T2 is ignored
    start = 1'b1; write = 1'b0; addr_in = 16'h4444; bus.data_in = 8'h5E;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; write = 1'b1; addr_in = 16'h9999; wdata = 8'h11;
    tick();
    start = 1'b0;
    chk("t6a_done", 32'(done), 32'(1));
    chk("t6a_addr", 32'(bus.MR_addr_out), 32'(16'h4444));
    chk("t6a_rvalid", 32'(rdata_valid), 32'(1));
    chk("t6a_rdata", 32'(rdata), 32'(8'h5E));
    tick();
    chk("t6a_idle", 32'(busy), 32'(0));

    // 6b: reset in the middle of T2
    start = 1'b1; write = 1'b0; addr_in = 16'h6666;
    tick();
    start = 1'b0;
    tick();
    chk("t6b_rd_t2", 32'(bus.MR_RD_L), 32'(0));
    #1 rst_L = 1'b0;
    #1;
    chk("t6b_busy", 32'(busy), 32'(0));
    chk("t6b_mreq", 32'(bus.MR_MREQ_L), 32'(1));
    chk("t6b_rd", 32'(bus.MR_RD_L), 32'(1));
    chk("t6b_rdata", 32'(rdata), 32'(0));
    tick();
    rst_L = 1'b1;
    tick();
    chk("t6b_idle", 32'(busy), 32'(0));

    // recovery read after reset
    run_cycle(1'b0, 16'h0F0F, 8'h00, 0, 8'h42, 8'h42, lat, ab, c1);
    chk("t7_latency", 32'(lat), 32'(3));
    chk("t7_rdata", 32'(rdata), 32'(8'h42));
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
